// File: rtl/mips_data_bus.sv
// mips_data_bus: data RAM plus LED, timer/compare and TX byte FIFO peripherals for the MIPS core
module mips_data_bus #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wemem,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [31:0] memdataout,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] A_LED = 32'hFFFF_0000;
    localparam logic [31:0] A_TMR = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP = 32'hFFFF_0008;
    localparam logic [31:0] A_ST  = 32'hFFFF_000C;
    localparam logic [31:0] A_TX  = 32'hFFFF_0010;
    localparam logic [31:0] A_CTL = 32'hFFFF_0014;
    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [31:0]   count, cmp;
    logic [1:0]    ctrl;
    logic          match, overflow;
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic          is_ram, full, empty, push, pop, accept, hit, st_wr;
    logic [3:0]    cnt_sat;
    logic [AW-1:0] ridx;
    always_comb begin
        is_ram     = addr[31:28] == 4'd0;
        ridx       = addr[AW+1:2];
        full       = cnt == CW'(FIFO_DEPTH);
        empty      = cnt == '0;
        push       = wemem && addr == A_TX;
        pop        = !empty && tx_ready;
        accept     = push && (!full || pop);
        st_wr      = wemem && addr == A_ST;
        hit        = ctrl[1] && cmp != 32'd0 && count == cmp;
        cnt_sat    = 32'(cnt) > 32'd15 ? 4'd15 : 4'(cnt);
        tx_valid   = !empty;
        tx_data    = empty ? 8'd0 : fifo[rp];
        irq        = match && ctrl[0];
        memdataout = is_ram         ? ram[ridx] :
                     addr == A_LED  ? {24'd0, leds} :
                     addr == A_TMR  ? count :
                     addr == A_CMP  ? cmp :
                     addr == A_ST   ? {24'd0, cnt_sat, overflow, match, empty, full} :
                     addr == A_CTL  ? {30'd0, ctrl} : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (wemem && is_ram) ram[ridx] <= writeData;
        if (accept) fifo[wp] <= writeData[7:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            leds     <= '0;
            count    <= '0;
            cmp      <= '0;
            ctrl     <= '0;
            match    <= 1'b0;
            overflow <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
        end else begin
            if (wemem && addr == A_LED) leds <= writeData[7:0];
            if (wemem && addr == A_CMP) cmp <= writeData;
            if (wemem && addr == A_CTL) ctrl <= writeData[1:0];
            count    <= (wemem && addr == A_TMR) ? writeData : hit ? 32'd0 : ctrl[1] ? count + 32'd1 : count;
            match    <= hit || (match && !(st_wr && writeData[2]));
            overflow <= (push && full && !pop) || (overflow && !(st_wr && writeData[3]));
            if (accept) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            cnt      <= cnt + CW'(accept) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_mips_data_bus.sv
// tb_mips_data_bus: randomized and directed checks of mips_data_bus against a queue-based model
module tb_mips_data_bus;
    localparam logic [31:0] A_LED = 32'hFFFF_0000;
    localparam logic [31:0] A_TMR = 32'hFFFF_0004;
    localparam logic [31:0] A_CMP = 32'hFFFF_0008;
    localparam logic [31:0] A_ST  = 32'hFFFF_000C;
    localparam logic [31:0] A_TX  = 32'hFFFF_0010;
    localparam logic [31:0] A_CTL = 32'hFFFF_0014;
    logic        clk = 1'b0, reset, wemem, tx_ready, tx_valid, irq;
    logic [31:0] addr, writeData, memdataout;
    logic [7:0]  leds, tx_data;
    int tests = 0, fails = 0;
    logic [7:0]  m_leds;
    logic [31:0] m_count, m_cmp;
    logic [1:0]  m_ctrl;
    bit          m_match, m_ovf;
    logic [7:0]  q[$];
    logic [31:0] m_ram [64];
    bit          m_known [64];

    always #5 clk = ~clk;

    mips_data_bus dut (
        .clk(clk), .reset(reset), .wemem(wemem), .addr(addr), .writeData(writeData),
        .memdataout(memdataout), .leds(leds), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .irq(irq)
    );

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int n = q.size();
        if (a[31:28] == 4'd0) return m_ram[a[7:2]];
        if (a == A_LED) return {24'd0, m_leds};
        if (a == A_TMR) return m_count;
        if (a == A_CMP) return m_cmp;
        if (a == A_ST) return {24'd0, 4'(n > 15 ? 15 : n), m_ovf, m_match, n == 0, n == 8};
        if (a == A_CTL) return {30'd0, m_ctrl};
        return 32'd0;
    endfunction

    task automatic model_step;
        bit pop, push, full, hit;
        if (wemem && addr[31:28] == 4'd0) begin
            m_ram[addr[7:2]] = writeData;
            m_known[addr[7:2]] = 1'b1;
        end
        if (reset) begin
            m_leds = 0; m_count = 0; m_cmp = 0; m_ctrl = 0; m_match = 0; m_ovf = 0;
            q.delete();
        end else begin
            pop  = q.size() != 0 && tx_ready;
            push = wemem && addr == A_TX;
            full = q.size() == 8;
            hit  = m_ctrl[1] && m_cmp != 0 && m_count == m_cmp;
            if (wemem && addr == A_ST && writeData[2]) m_match = 0;
            if (hit) m_match = 1;
            if (wemem && addr == A_ST && writeData[3]) m_ovf = 0;
            if (push && full && !pop) m_ovf = 1;
            if (wemem && addr == A_TMR) m_count = writeData;
            else if (hit) m_count = 0;
            else if (m_ctrl[1]) m_count = m_count + 1;
            if (pop) void'(q.pop_front());
            if (push && (!full || pop)) q.push_back(writeData[7:0]);
            if (wemem && addr == A_LED) m_leds = writeData[7:0];
            if (wemem && addr == A_CMP) m_cmp = writeData;
            if (wemem && addr == A_CTL) m_ctrl = writeData[1:0];
        end
    endtask

    task automatic set_in(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy, input logic rst);
        wemem = we; addr = a; writeData = d; tx_ready = rdy; reset = rst;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        set_in(we, a, d, rdy, 1'b0);
        tick();
    endtask

    task automatic test_reset;
        logic [31:0] ra [5] = '{A_TMR, A_CMP, A_CTL, A_TX, A_ST};
        logic [31:0] re [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h2};
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, ra[i], 32'h0, 1'b0, 1'b0);
            tests++;
            if (memdataout !== re[i]) begin fails++; $display("FAIL reset_read %h: got %h exp %h", ra[i], memdataout, re[i]); end
            tests++;
            if ({leds, tx_data, tx_valid, irq} !== 18'd0) begin fails++; $display("FAIL reset_outs: leds %h tx_data %h tx_valid %b irq %b exp all 0", leds, tx_data, tx_valid, irq); end
            tick();
        end
    endtask

    task automatic test_ram;
        logic [31:0] ra [4] = '{32'h10, 32'h14, 32'h13, 32'h0FFF_FF10};
        logic [31:0] re [4] = '{32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF};
        cyc(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        cyc(1'b1, 32'h14, 32'h12345678, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, ra[i], 32'h0, 1'b0, 1'b0);
            tests++;
            if (memdataout !== re[i]) begin fails++; $display("FAIL ram_read %h: got %h exp %h", ra[i], memdataout, re[i]); end
            tick();
        end
        for (int i = 0; i < 20; i++) cyc(1'b1, {4'h0, 28'($urandom)}, $urandom, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [31:0] a = {4'h0, 28'($urandom)};
            set_in(1'b0, a, 32'h0, 1'b0, 1'b0);
            if (m_known[a[7:2]]) begin
                tests++;
                if (memdataout !== m_read(a)) begin fails++; $display("FAIL ram_rand %h: got %h exp %h", a, memdataout, m_read(a)); end
            end
            tick();
        end
    endtask

    task automatic test_led_unmapped;
        cyc(1'b1, A_LED, 32'h1A5, 1'b0);
        set_in(1'b0, A_LED, 32'h0, 1'b0, 1'b0);
        tests++;
        if (leds !== 8'hA5 || memdataout !== 32'hA5) begin fails++; $display("FAIL led_write: leds %h read %h exp a5", leds, memdataout); end
        tick();
        set_in(1'b0, 32'hFFFF_0100, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h exp 0", memdataout); end
        tick();
        cyc(1'b1, 32'hFFFF_0100, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 1'b0);
        set_in(1'b0, A_CMP, 32'h0, 1'b0, 1'b0);
        tests++;
        if (leds !== 8'hA5 || memdataout !== 32'h0 || tx_valid !== 1'b0) begin fails++; $display("FAIL unmapped_write: leds %h cmp %h txv %b exp a5 0 0", leds, memdataout, tx_valid); end
        tick();
        set_in(1'b0, 32'h1000_0000, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'h0) begin fails++; $display("FAIL unmapped_hi: got %h exp 0", memdataout); end
        tick();
    endtask

    task automatic test_timer;
        cyc(1'b1, A_CMP, 32'd5, 1'b0);
        cyc(1'b1, A_CTL, 32'd3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ec = i < 6 ? i : i - 6;
            set_in(1'b0, A_TMR, 32'h0, 1'b0, 1'b0);
            tests++;
            if (memdataout !== ec || irq !== (i >= 6)) begin fails++; $display("FAIL timer_seq %0d: count %0d irq %b exp %0d %b", i, memdataout, irq, ec, i >= 6); end
            tick();
        end
        cyc(1'b1, A_ST, 32'h4, 1'b0);
        cyc(1'b1, A_CTL, 32'h0, 1'b0);
        set_in(1'b0, A_ST, 32'h0, 1'b0, 1'b0);
        tests++;
        if (irq !== 1'b0 || memdataout[2] !== 1'b0) begin fails++; $display("FAIL timer_clear: irq %b match %b exp 0 0", irq, memdataout[2]); end
        tick();
        set_in(1'b0, A_TMR, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'd4) begin fails++; $display("FAIL timer_stop: got %0d exp 4", memdataout); end
        tick();
    endtask

    task automatic test_timer_corner;
        cyc(1'b1, A_CMP, 32'd3, 1'b0);
        cyc(1'b1, A_TMR, 32'd0, 1'b0);
        cyc(1'b1, A_CTL, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, A_TMR, 32'h0, 1'b0);
        cyc(1'b1, A_ST, 32'h4, 1'b0);
        set_in(1'b0, A_ST, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout[2] !== 1'b1 || irq !== 1'b0) begin fails++; $display("FAIL set_wins: match %b irq %b exp 1 0", memdataout[2], irq); end
        tick();
        cyc(1'b1, A_TMR, 32'd100, 1'b0);
        set_in(1'b0, A_TMR, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'd100) begin fails++; $display("FAIL timer_write: got %0d exp 100", memdataout); end
        tick();
        set_in(1'b0, A_TMR, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'd101) begin fails++; $display("FAIL timer_after_write: got %0d exp 101", memdataout); end
        tick();
        cyc(1'b1, A_CTL, 32'h0, 1'b0);
        cyc(1'b1, A_ST, 32'h4, 1'b0);
    endtask

    task automatic test_fifo_fill;
        for (int i = 1; i <= 9; i++) cyc(1'b1, A_TX, i, 1'b0);
        set_in(1'b0, A_ST, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'h89 || tx_valid !== 1'b1 || tx_data !== 8'h01) begin fails++; $display("FAIL fifo_full: status %h txv %b txd %h exp 89 1 01", memdataout, tx_valid, tx_data); end
        tick();
        for (int i = 1; i <= 8; i++) begin
            set_in(1'b0, A_ST, 32'h0, 1'b1, 1'b0);
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin fails++; $display("FAIL fifo_drain %0d: txv %b txd %h exp 1 %h", i, tx_valid, tx_data, 8'(i)); end
            tick();
        end
        set_in(1'b0, A_ST, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'h0A || tx_valid !== 1'b0 || tx_data !== 8'h0) begin fails++; $display("FAIL fifo_empty: status %h txv %b txd %h exp 0a 0 00", memdataout, tx_valid, tx_data); end
        tick();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 8; i++) cyc(1'b1, A_TX, 32'h10 + i, 1'b0);
        set_in(1'b1, A_TX, 32'h55, 1'b1, 1'b0);
        tests++;
        if (tx_data !== 8'h10) begin fails++; $display("FAIL b2b_head: got %h exp 10", tx_data); end
        tick();
        set_in(1'b0, A_ST, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'h89) begin fails++; $display("FAIL b2b_status: got %h exp 89", memdataout); end
        tick();
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e = i < 7 ? 8'(32'h11 + i) : 8'h55;
            set_in(1'b0, A_ST, 32'h0, 1'b1, 1'b0);
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== e) begin fails++; $display("FAIL b2b_drain %0d: txv %b txd %h exp 1 %h", i, tx_valid, tx_data, e); end
            tick();
        end
        cyc(1'b1, A_ST, 32'h8, 1'b0);
        set_in(1'b0, A_ST, 32'h0, 1'b0, 1'b0);
        tests++;
        if (memdataout !== 32'h02 || tx_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: status %h txv %b exp 02 0", memdataout, tx_valid); end
        tick();
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) cyc(1'b1, A_TX, 32'hA0 + i, 1'b0);
        cyc(1'b1, A_LED, 32'hFF, 1'b0);
        cyc(1'b1, A_TMR, 32'h0, 1'b0);
        cyc(1'b1, A_CMP, 32'd2, 1'b0);
        cyc(1'b1, A_CTL, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, A_TMR, 32'h0, 1'b0);
        set_in(1'b0, A_TMR, 32'h0, 1'b0, 1'b1);
        tests++;
        if (irq !== 1'b1 || tx_valid !== 1'b1 || leds !== 8'hFF) begin fails++; $display("FAIL pre_reset: irq %b txv %b leds %h exp 1 1 ff", irq, tx_valid, leds); end
        tick();
        for (int i = 0; i < 2; i++) begin
            set_in(1'b0, A_TMR, 32'h0, 1'b1, 1'b0);
            tests++;
            if (tx_valid !== 1'b0 || tx_data !== 8'h0 || memdataout !== 32'h0 || leds !== 8'h0 || irq !== 1'b0) begin
                fails++; $display("FAIL mid_reset %0d: txv %b txd %h count %h leds %h irq %b exp all 0", i, tx_valid, tx_data, memdataout, leds, irq);
            end
            tick();
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, d;
            int sel = $urandom_range(0, 9);
            d = $urandom;
            case (sel)
                0, 1: a = {4'h0, 28'($urandom)};
                2: a = A_LED;
                3: begin a = A_TMR; d = $urandom_range(0, 12); end
                4: begin a = A_CMP; d = $urandom_range(0, 12); end
                5: a = A_ST;
                6, 7: a = A_TX;
                8: a = A_CTL;
                default: a = 32'hFFFF_0018 + ($urandom_range(0, 100) << 2);
            endcase
            set_in($urandom_range(0, 2) != 0, a, d, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
            if (a[31:28] != 4'd0 || m_known[a[7:2]]) begin
                tests++;
                if (memdataout !== m_read(a)) begin fails++; $display("FAIL rnd_read %0d @%h: got %h exp %h", i, a, memdataout, m_read(a)); end
            end
            tests++;
            if (leds !== m_leds) begin fails++; $display("FAIL rnd_leds %0d: got %h exp %h", i, leds, m_leds); end
            tests++;
            if (tx_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_txv %0d: got %b exp %b", i, tx_valid, q.size() != 0); end
            tests++;
            if (tx_data !== (q.size() != 0 ? q[0] : 8'h0)) begin fails++; $display("FAIL rnd_txd %0d: got %h exp %h", i, tx_data, q.size() != 0 ? q[0] : 8'h0); end
            tests++;
            if (irq !== (m_match && m_ctrl[0])) begin fails++; $display("FAIL rnd_irq %0d: got %b exp %b", i, irq, m_match && m_ctrl[0]); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_unmapped();
        test_timer();
        test_timer_corner();
        test_fifo_fill();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
